// File: rtl/add_tree_pkg.sv
// Shared sizing helpers for the pipelined adder tree.
// ADD_TREE_ACC_EN selects the accumulating final stage.
package add_tree_pkg;

`ifdef ADD_TREE_ACC_EN
  localparam bit ACC_EN = 1'b1;
`else
  localparam bit ACC_EN = 1'b0;
`endif

  function automatic int clog2(input int n);
    int r;
    int v;
    r = 0;
    v = 1;
    while (v < n) begin
      v = v * 2;
      r = r + 1;
    end
    return r;
  endfunction

  function automatic int num_stages(input int numIn, input int radix);
    int n;
    int s;
    n = numIn;
    s = 0;
    while (n > 1) begin
      n = (n + radix - 1) / radix;
      s = s + 1;
    end
    return (s < 1) ? 1 : s;
  endfunction

  function automatic int nodes_at_level(input int numIn, input int radix, input int k);
    int n;
    n = numIn;
    for (int i = 0; i < k; i++) begin
      n = (n + radix - 1) / radix;
    end
    return n;
  endfunction

  // Operands covered by one node at level k, capped at numIn, sets the width.
  function automatic int level_width(input int inW, input int numIn, input int radix, input int k);
    int p;
    p = 1;
    for (int i = 0; i < k; i++) begin
      p = p * radix;
      if (p > numIn) p = numIn;
    end
    return inW + clog2(p);
  endfunction

endpackage

// File: rtl/add_tree_stage.sv
// One level of the adder tree: zero-padded grouping, node adders and the
// elastic valid/data register. With ACC set the register accumulates.
module add_tree_stage
  import add_tree_pkg::*;
#(
  parameter int IN_W_L  = 8,
  parameter int N_IN    = 9,
  parameter int RADIX   = 3,
  parameter int N_OUT   = 3,
  parameter int OUT_W_L = 10,
  parameter bit ACC     = 1'b0
) (
  input  logic                     clk,
  input  logic                     rst_n,
  input  logic                     valid_i,
  input  logic                     clr_i,
  input  logic [N_IN*IN_W_L-1:0]   data_i,
  input  logic                     adv_next_i,
  output logic                     adv_o,
  output logic                     valid_o,
  output logic                     clr_o,
  output logic [N_OUT*OUT_W_L-1:0] data_o
);

  localparam int PAD_W = N_OUT * RADIX * IN_W_L;

  logic [PAD_W-1:0]         padded;
  logic [N_OUT*OUT_W_L-1:0] sum_d;
  logic [N_OUT*OUT_W_L-1:0] data_d;
  logic [N_OUT*OUT_W_L-1:0] data_q;
  logic                     valid_q;
  logic                     clr_q;

  assign padded = PAD_W'(data_i);

  always_comb begin
    sum_d = '0;
    for (int n = 0; n < N_OUT; n++) begin
      for (int c = 0; c < RADIX; c++) begin
        sum_d[n*OUT_W_L +: OUT_W_L] = sum_d[n*OUT_W_L +: OUT_W_L]
                                    + OUT_W_L'(padded[(n*RADIX+c)*IN_W_L +: IN_W_L]);
      end
    end
  end

  if (ACC) begin : g_acc
    assign data_d = clr_i ? sum_d : data_q + sum_d;
  end else begin : g_plain
    assign data_d = sum_d;
  end

  assign adv_o = !valid_q || adv_next_i;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      valid_q <= 1'b0;
      clr_q   <= 1'b0;
      data_q  <= '0;
    end else if (adv_o) begin
      valid_q <= valid_i;
      if (valid_i) begin
        clr_q  <= clr_i;
        data_q <= data_d;
      end
    end
  end

  assign valid_o = valid_q;
  assign clr_o   = clr_q;
  assign data_o  = data_q;

endmodule

// File: rtl/add_tree_pipe.sv
// Pipelined multi-operand adder tree with valid/ready backpressure.
// Define ADD_TREE_ACC_EN to add acc_clr_i and a running accumulator at the output.
module add_tree_pipe
  import add_tree_pkg::*;
#(
  parameter int NUM_IN    = 9,
  parameter int IN_W      = 8,
  parameter int RADIX     = 3,
  parameter int ACC_GUARD = 8,
  localparam int OUT_W    = IN_W + clog2(NUM_IN),
  localparam int SUM_W    = OUT_W + (ACC_EN ? ACC_GUARD : 0)
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   in_valid_i,
  output logic                   in_ready_o,
  input  logic [NUM_IN*IN_W-1:0] in_data_i,
`ifdef ADD_TREE_ACC_EN
  input  logic                   acc_clr_i,
`endif
  output logic                   out_valid_o,
  input  logic                   out_ready_i,
  output logic [SUM_W-1:0]       out_sum_o
);

  localparam int S = num_stages(NUM_IN, RADIX);

  logic [S+1:1] adv;
  logic         clrIn;
  logic         unused_clr;

`ifdef ADD_TREE_ACC_EN
  assign clrIn = acc_clr_i;
`else
  assign clrIn = 1'b0;
`endif

  assign adv[S+1] = out_ready_i;

  for (genvar k = 1; k <= S; k++) begin : g_st
    localparam int  WI   = level_width(IN_W, NUM_IN, RADIX, k-1);
    localparam int  NI   = nodes_at_level(NUM_IN, RADIX, k-1);
    localparam int  NO   = nodes_at_level(NUM_IN, RADIX, k);
    localparam bit  LAST = (k == S);
    localparam int  WO   = LAST ? SUM_W : level_width(IN_W, NUM_IN, RADIX, k);

    logic             validIn;
    logic             clrIn_l;
    logic [NI*WI-1:0] dataIn;
    logic             valid;
    logic             clr;
    logic [NO*WO-1:0] data;

    if (k == 1) begin : g_first
      assign validIn = in_valid_i;
      assign clrIn_l = clrIn;
      assign dataIn  = in_data_i;
    end else begin : g_inner
      assign validIn = g_st[k-1].valid;
      assign clrIn_l = g_st[k-1].clr;
      assign dataIn  = g_st[k-1].data;
    end

    add_tree_stage #(
      .IN_W_L (WI),
      .N_IN   (NI),
      .RADIX  (RADIX),
      .N_OUT  (NO),
      .OUT_W_L(WO),
      .ACC    (LAST && ACC_EN)
    ) u_stage (
      .clk       (clk),
      .rst_n     (rst_n),
      .valid_i   (validIn),
      .clr_i     (clrIn_l),
      .data_i    (dataIn),
      .adv_next_i(adv[k+1]),
      .adv_o     (adv[k]),
      .valid_o   (valid),
      .clr_o     (clr),
      .data_o    (data)
    );
  end

  // Gate with rst_n so nothing is offered as accepted while reset is held.
  assign in_ready_o  = rst_n && adv[1];
  assign out_valid_o = g_st[S].valid;
  assign out_sum_o   = g_st[S].data;
  assign unused_clr  = g_st[S].clr;

endmodule

// File: tb/tb_add_tree_pipe.sv
// Self-checking bench for add_tree_pipe: directed scenarios plus a random
// stream, scored against a queue-based arithmetic model.
module tb_add_tree_pipe;

  localparam int NUM_IN    = 9;
  localparam int IN_W      = 8;
  localparam int RADIX     = 3;
  localparam int ACC_GUARD = 8;
  localparam int OUT_W     = 12;
`ifdef ADD_TREE_ACC_EN
  localparam int SUM_W     = OUT_W + ACC_GUARD;
`else
  localparam int SUM_W     = OUT_W;
`endif
  localparam logic [63:0] SUM_MASK = (64'd1 << SUM_W) - 64'd1;

  logic                   clk;
  logic                   rst_n;
  logic                   inValid;
  logic                   inReady;
  logic [NUM_IN*IN_W-1:0] inData;
  logic                   accClr;
  logic                   outValid;
  logic                   outReady;
  logic [SUM_W-1:0]       outSum;

  int          assertCount;
  int          failCount;
  logic [63:0] expQ[$];
  logic [63:0] accModel;
  logic        sInReady;
  logic        sOutValid;
  logic [63:0] sOutSum;
  logic        sAccepted;
  logic [63:0] stallSum;
  logic [63:0] postSum;
  int          cyc;
  int          accCnt;

  add_tree_pipe #(
    .NUM_IN   (NUM_IN),
    .IN_W     (IN_W),
    .RADIX    (RADIX),
    .ACC_GUARD(ACC_GUARD)
  ) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .in_valid_i (inValid),
    .in_ready_o (inReady),
    .in_data_i  (inData),
`ifdef ADD_TREE_ACC_EN
    .acc_clr_i  (accClr),
`endif
    .out_valid_o(outValid),
    .out_ready_i(outReady),
    .out_sum_o  (outSum)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  function automatic logic [63:0] sumOf(input logic [NUM_IN*IN_W-1:0] d);
    logic [63:0] s;
    s = 64'd0;
    for (int k = 0; k < NUM_IN; k++) s = s + 64'(d[k*IN_W +: IN_W]);
    return s;
  endfunction

  function automatic logic [NUM_IN*IN_W-1:0] allOps(input int v);
    logic [NUM_IN*IN_W-1:0] d;
    for (int k = 0; k < NUM_IN; k++) d[k*IN_W +: IN_W] = IN_W'(v);
    return d;
  endfunction

  function automatic logic [NUM_IN*IN_W-1:0] seqOps();
    logic [NUM_IN*IN_W-1:0] d;
    for (int k = 0; k < NUM_IN; k++) d[k*IN_W +: IN_W] = IN_W'(k + 1);
    return d;
  endfunction

  function automatic logic [NUM_IN*IN_W-1:0] randomOps();
    logic [NUM_IN*IN_W-1:0] d;
    for (int k = 0; k < NUM_IN; k++) d[k*IN_W +: IN_W] = IN_W'($urandom);
    return d;
  endfunction

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertCount++;
    assert (observed === expected)
    else begin
      failCount++;
      $error("[TB] FAIL %s observed=%0d expected=%0d", tag, observed, expected);
    end
  endtask

  task automatic applyStimulus(input logic v, input logic [NUM_IN*IN_W-1:0] d, input logic r);
    inValid  = v;
    inData   = d;
    outReady = r;
  endtask

  // One cycle: sample mid low-phase, score any delivery, record any acceptance.
  task automatic step();
    logic [63:0] s;
    #1;
    sInReady  = inReady;
    sOutValid = outValid;
    sOutSum   = 64'(outSum);
    if (outValid && outReady) begin
      if (expQ.size() == 0) checkOutput("spurious_beat", 64'(expQ.size()), 64'd1);
      else checkOutput("stream_sum", 64'(outSum), expQ.pop_front());
    end
    sAccepted = inValid && inReady;
    if (sAccepted) begin
      s = sumOf(inData);
`ifdef ADD_TREE_ACC_EN
      accModel = (accClr ? s : accModel + s) & SUM_MASK;
      expQ.push_back(accModel);
`else
      expQ.push_back(s);
`endif
    end
    @(negedge clk);
  endtask

  initial begin
    assertCount = 0;
    failCount   = 0;
    accModel    = 64'd0;
    rst_n       = 1'b0;
    accClr      = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    repeat (2) @(negedge clk);
    #1;
    checkOutput("reset_out_valid", 64'(outValid), 64'd0);
    checkOutput("reset_out_sum", 64'(outSum), 64'd0);
    checkOutput("reset_in_ready", 64'(inReady), 64'd0);
    @(negedge clk);
    rst_n = 1'b1;

    $display("[TB] single beat latency");
    applyStimulus(1'b1, seqOps(), 1'b1);
    step();
    checkOutput("single_accept", 64'(sInReady), 64'd1);
    applyStimulus(1'b0, '0, 1'b1);
    step();
    checkOutput("single_lat1_valid", 64'(sOutValid), 64'd0);
    step();
    checkOutput("single_lat2_valid", 64'(sOutValid), 64'd1);
    checkOutput("single_sum", sOutSum, 64'd45);
    step();
    checkOutput("single_after_valid", 64'(sOutValid), 64'd0);

    $display("[TB] back-to-back beats");
    for (int c = 1; c <= 5; c++) begin
      applyStimulus(1'b1, allOps(c), 1'b1);
      step();
      checkOutput("b2b_in_ready", 64'(sInReady), 64'd1);
      if (c >= 3) checkOutput("b2b_sum", sOutSum, 64'(9 * (c - 2)));
    end
    applyStimulus(1'b0, '0, 1'b1);
    for (int c = 4; c <= 5; c++) begin
      step();
      checkOutput("b2b_drain_valid", 64'(sOutValid), 64'd1);
      checkOutput("b2b_drain_sum", sOutSum, 64'(9 * c));
    end
    step();
    checkOutput("b2b_empty", 64'(expQ.size()), 64'd0);

    $display("[TB] max and zero operands");
    applyStimulus(1'b1, allOps(255), 1'b1);
    step();
    applyStimulus(1'b1, allOps(0), 1'b1);
    step();
    applyStimulus(1'b0, '0, 1'b1);
    step();
    checkOutput("max_sum", sOutSum, 64'd2295);
    step();
    checkOutput("zero_valid", 64'(sOutValid), 64'd1);
    checkOutput("zero_sum", sOutSum, 64'd0);

    $display("[TB] stall with backpressure");
    cyc      = 0;
    accCnt   = 0;
    stallSum = 64'd0;
    inData   = randomOps();
    while (cyc < 60 && (accCnt < 6 || expQ.size() > 0)) begin
      cyc++;
      outReady = !(cyc >= 3 && cyc <= 6);
      inValid  = (accCnt < 6);
      step();
      if (sAccepted && accCnt == 0) stallSum = sumOf(inData);
      if (cyc >= 3 && cyc <= 6) begin
        checkOutput("stall_in_ready", 64'(sInReady), 64'd0);
        checkOutput("stall_valid", 64'(sOutValid), 64'd1);
        checkOutput("stall_hold_sum", sOutSum, stallSum);
      end
      if (cyc == 7) checkOutput("resume_in_ready", 64'(sInReady), 64'd1);
      if (sAccepted) begin
        accCnt++;
        inData = randomOps();
      end
    end
    checkOutput("stall_all_accepted", 64'(accCnt), 64'd6);
    checkOutput("stall_drained", 64'(expQ.size()), 64'd0);

    $display("[TB] random stream");
    for (int i = 0; i < 300; i++) begin
      applyStimulus(($urandom % 4) != 0, randomOps(), ($urandom % 3) != 0);
      accClr = ($urandom % 3) == 0;
      step();
    end
    accClr = 1'b1;
    applyStimulus(1'b0, '0, 1'b1);
    for (int i = 0; i < 10 && expQ.size() > 0; i++) step();
    checkOutput("random_drained", 64'(expQ.size()), 64'd0);

    $display("[TB] reset with beats in flight");
    applyStimulus(1'b1, randomOps(), 1'b1);
    step();
    applyStimulus(1'b1, randomOps(), 1'b1);
    step();
    inValid = 1'b0;
    rst_n   = 1'b0;
    #1;
    checkOutput("midreset_out_valid", 64'(outValid), 64'd0);
    checkOutput("midreset_out_sum", 64'(outSum), 64'd0);
    checkOutput("midreset_in_ready", 64'(inReady), 64'd0);
    expQ.delete();
    accModel = 64'd0;
    @(negedge clk);
    rst_n = 1'b1;
    applyStimulus(1'b1, randomOps(), 1'b1);
    postSum = sumOf(inData);
    step();
    checkOutput("post_reset_accept", 64'(sAccepted), 64'd1);
    applyStimulus(1'b0, '0, 1'b1);
    step();
    checkOutput("post_reset_gap", 64'(sOutValid), 64'd0);
    step();
    checkOutput("post_reset_valid", 64'(sOutValid), 64'd1);
    checkOutput("post_reset_sum", sOutSum, postSum);
    checkOutput("post_reset_drained", 64'(expQ.size()), 64'd0);

`ifdef ADD_TREE_ACC_EN
    $display("[TB] accumulator");
    for (int i = 0; i < 6; i++) begin
      applyStimulus(i < 4, seqOps(), 1'b1);
      accClr = (i == 0 || i == 3);
      step();
      if (i == 2) checkOutput("acc_first", sOutSum, 64'd45);
      if (i == 3) checkOutput("acc_second", sOutSum, 64'd90);
      if (i == 4) checkOutput("acc_third", sOutSum, 64'd135);
      if (i == 5) checkOutput("acc_cleared", sOutSum, 64'd45);
    end
    accClr = 1'b1;
`endif

    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
